// File: rtl/mfu_mac.sv
// mfu_mac: precision-scalable streaming multiply-accumulate with valid/ready result output.
// Optional MFU_MAC_SAT_EN: saturate every accumulate instead of wrapping.
module mfu_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              overflow
);
    localparam int HW = DATA_W / 2;
    localparam int QW = DATA_W / 4;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_last_q, s1_last_d;
    logic [ACC_W-1:0] s1_psum_q, s1_psum_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic             overflow_q, overflow_d;

    logic [ACC_W-1:0] p_s, p_u, p_h, p_q, psum;
    logic [ACC_W-1:0] sum, sat, res;
    logic             stall, accept, fire, done, ovf;

    // Products are formed at ACC_W on extended operands; the true values always fit.
    always_comb begin
        p_s = ACC_W'($signed(a)) * ACC_W'($signed(b));
        p_u = ACC_W'(a) * ACC_W'(b);
        p_h = '0;
        p_q = '0;
        for (int k = 0; k < 2; k++)
            p_h = p_h + ACC_W'($signed(a[k*HW +: HW])) * ACC_W'($signed(b[k*HW +: HW]));
        for (int k = 0; k < 4; k++)
            p_q = p_q + ACC_W'($signed(a[k*QW +: QW])) * ACC_W'($signed(b[k*QW +: QW]));
        psum = (mode == 2'd0) ? p_s : (mode == 2'd1) ? p_h : (mode == 2'd2) ? p_q : p_u;
    end

    always_comb begin
        stall  = out_valid_q & ~out_ready;
        accept = in_valid & ~stall;
        fire   = s1_valid_q & ~stall;
        done   = fire & s1_last_q;
        sum    = acc_q + s1_psum_q;
        ovf    = (acc_q[ACC_W-1] == s1_psum_q[ACC_W-1]) & (sum[ACC_W-1] != acc_q[ACC_W-1]);
        sat    = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`ifdef MFU_MAC_SAT_EN
        res    = ovf ? sat : sum;
`else
        res    = sum;
`endif
        s1_valid_d  = stall ? s1_valid_q : accept;
        s1_psum_d   = accept ? psum : s1_psum_q;
        s1_last_d   = accept ? in_last : s1_last_q;
        acc_d       = fire ? (s1_last_q ? '0 : res) : acc_q;
        ovf_acc_d   = fire ? (~s1_last_q & (ovf_acc_q | ovf)) : ovf_acc_q;
        out_valid_d = done | stall;
        out_data_d  = done ? res : out_data_q;
        // A freshly written result takes priority over clearing on handshake.
        overflow_d  = done ? (ovf_acc_q | ovf) : (out_valid_q & out_ready) ? 1'b0 : overflow_q;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_psum_q   <= '0;
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_psum_q   <= s1_psum_d;
            acc_q       <= acc_d;
            ovf_acc_q   <= ovf_acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_ready  = ~stall;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_mfu_mac.sv
// tb_mfu_mac: directed test of mfu_mac; a default instance plus an ACC_W=18 instance
// share the same stimulus so the narrow one can exercise overflow.
module tb_mfu_mac;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  a = 8'd0, b = 8'd0;
    logic        in_ready, out_valid, overflow;
    logic [31:0] out_data;
    logic        in_ready18, out_valid18, overflow18;
    logic [17:0] out_data18;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] d;
    logic [17:0] d18;
    logic        ov, ov18;
    int          lat;

    always #5 clk = ~clk;

    mfu_mac u_dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .mode(mode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .overflow(overflow)
    );

    mfu_mac #(.DATA_W(8), .ACC_W(18)) u_dut18 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready18), .in_last(in_last),
        .mode(mode), .a(a), .b(b), .out_valid(out_valid18), .out_ready(out_ready),
        .out_data(out_data18), .overflow(overflow18)
    );

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] m, input logic [7:0] av, input logic [7:0] bv, input logic l);
        int w;
        in_valid = 1'b1; mode = m; a = av; b = bv; in_last = l;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic get(output logic [31:0] rd, output logic [17:0] rd18, output logic rov,
                       output logic rov18, output int rlat);
        rlat = 1;
        @(negedge clk);
        while (!out_valid && rlat < 20) begin
            rlat++;
            @(negedge clk);
        end
        if (!out_valid) chk("get_valid", out_valid, 1);
        rd = out_data; rd18 = out_data18; rov = overflow; rov18 = overflow18;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        send(2'd0, 8'hFD, 8'h07, 1'b1);
        get(d, d18, ov, ov18, lat);
        chk("m0_data", $signed(d), -21);
        chk("m0_latency", lat, 2);
        chk("m0_ovf", ov, 0);

        send(2'd1, 8'h3F, 8'h25, 1'b1);
        get(d, d18, ov, ov18, lat);
        chk("m1_data", $signed(d), 1);
        send(2'd2, 8'hFF, 8'h55, 1'b1);
        get(d, d18, ov, ov18, lat);
        chk("m2_data", $signed(d), -4);
        send(2'd3, 8'hFF, 8'hFF, 1'b1);
        get(d, d18, ov, ov18, lat);
        chk("m3_data", $signed(d), 65025);

        for (int i = 0; i < 4; i++) send(2'd0, 8'd127, 8'd127, i == 3);
        get(d, d18, ov, ov18, lat);
        chk("m0_4beat", $signed(d), 64516);
        send(2'd0, 8'd1, 8'd1, 1'b1);
        get(d, d18, ov, ov18, lat);
        chk("acc_cleared", $signed(d), 1);

        // Mixed modes within one packet, with an idle gap between beats.
        send(2'd1, 8'h3F, 8'h25, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        send(2'd3, 8'hFF, 8'hFF, 1'b1);
        get(d, d18, ov, ov18, lat);
        chk("mixed_gap", $signed(d), 65026);

        out_ready = 1'b0;
        send(2'd0, 8'd5, 8'd5, 1'b1);
        in_valid = 1'b1; mode = 2'd0; a = 8'd3; b = 8'd3; in_last = 1'b1;
        @(posedge clk);
        #1 a = 8'd4; b = 8'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", $signed(out_data), 25);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        get(d, d18, ov, ov18, lat);
        in_valid = 1'b0; in_last = 1'b0;
        chk("bp_res0", $signed(d), 25);
        get(d, d18, ov, ov18, lat);
        chk("bp_res1", $signed(d), 9);
        get(d, d18, ov, ov18, lat);
        chk("bp_res2", $signed(d), 16);

        send(2'd0, 8'd10, 8'd10, 1'b0);
        send(2'd0, 8'd10, 8'd10, 1'b0);
        @(posedge clk);
        #1 nrst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 nrst = 1'b1;
        send(2'd0, 8'd2, 8'd3, 1'b1);
        get(d, d18, ov, ov18, lat);
        chk("after_rst_data", $signed(d), 6);

        // 8 x (-128 * -128) = 131072: fits 32 bits, exceeds the 18-bit signed range.
        for (int i = 0; i < 8; i++) send(2'd0, 8'h80, 8'h80, i == 7);
        get(d, d18, ov, ov18, lat);
        chk("wide_data", $signed(d), 131072);
        chk("wide_ovf", ov, 0);
`ifdef MFU_MAC_SAT_EN
        chk("narrow_data", $signed(d18), 131071);
`else
        chk("narrow_data", $signed(d18), -131072);
`endif
        chk("narrow_ovf", ov18, 1);
        @(negedge clk);
        chk("narrow_ovf_clear", overflow18, 0);
        chk("idle_out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
